// File: rtl/rc4_prga_engine_if.sv
// Handshake and memory-bus bundle for the RC4 PRGA engine.
// master = engine side, slave = memories plus the controller that issues start.
interface rc4_prga_engine_if #(parameter int MSG_AW = 5);
  logic              start;
  logic              busy;
  logic              done;
  logic              ok;
  logic [7:0]        s_addr;
  logic [7:0]        s_wdata;
  logic              s_wren;
  logic [7:0]        s_rdata;
  logic [MSG_AW-1:0] e_addr;
  logic [7:0]        e_rdata;
  logic [MSG_AW-1:0] d_addr;
  logic [7:0]        d_wdata;
  logic              d_wren;

  modport master (
    input  start, s_rdata, e_rdata,
    output busy, done, ok, s_addr, s_wdata, s_wren, e_addr, d_addr, d_wdata, d_wren
  );

  modport slave (
    output start, s_rdata, e_rdata,
    input  busy, done, ok, s_addr, s_wdata, s_wren, e_addr, d_addr, d_wdata, d_wren
  );
endinterface

// File: rtl/rc4_prga_engine.sv
// RC4 keystream generation: decrypts MSG_LEN ROM bytes into the D RAM using the permuted S RAM.
// Define RC4_PLAINTEXT_CHECK_EN to abort on the first byte that is not a lowercase letter or space.
module rc4_prga_engine #(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = 5,
  parameter int RD_LAT  = 2
) (
  input  logic               clk,
  input  logic               reset,
  rc4_prga_engine_if.master  bus
);

  typedef enum logic [3:0] {
    IDLE, RD_I, WT_I, RD_J, WT_J, WR_I, WR_J, RD_F, WT_F, WR_D, DONE
  } state_t;

  localparam logic [1:0]        WT_INIT = 2'(RD_LAT - 1);
  localparam logic [MSG_AW-1:0] K_LAST  = MSG_AW'(MSG_LEN - 1);

  state_t            state;
  logic [1:0]        wcnt;
  logic [7:0]        i, j, si, sj;
  logic [MSG_AW-1:0] k;

`ifdef RC4_PLAINTEXT_CHECK_EN
  function automatic logic is_text(input logic [7:0] v);
    return (v >= 8'h61 && v <= 8'h7a) || (v == 8'h20);
  endfunction
`endif

  // Outputs are set on the edge entering the state they belong to, so every
  // branch below prepares the bus for the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wcnt        <= '0;
      i           <= '0;
      j           <= '0;
      si          <= '0;
      sj          <= '0;
      k           <= '0;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.ok      <= 1'b0;
      bus.s_addr  <= '0;
      bus.s_wdata <= '0;
      bus.s_wren  <= 1'b0;
      bus.e_addr  <= '0;
      bus.d_addr  <= '0;
      bus.d_wdata <= '0;
      bus.d_wren  <= 1'b0;
    end else begin
      bus.s_wren <= 1'b0;
      bus.d_wren <= 1'b0;
      bus.done   <= 1'b0;
      case (state)
        IDLE: begin
          bus.s_addr  <= '0;
          bus.s_wdata <= '0;
          bus.e_addr  <= '0;
          bus.d_addr  <= '0;
          bus.d_wdata <= '0;
          if (bus.start) begin
            i          <= 8'd1;
            j          <= '0;
            k          <= '0;
            bus.ok     <= 1'b0;
            bus.busy   <= 1'b1;
            bus.s_addr <= 8'd1;
            state      <= RD_I;
          end
        end
        RD_I: begin
          wcnt  <= WT_INIT;
          state <= WT_I;
        end
        WT_I: begin
          if (wcnt != 2'd0) begin
            wcnt <= wcnt - 2'd1;
          end else begin
            si         <= bus.s_rdata;
            j          <= j + bus.s_rdata;
            bus.s_addr <= j + bus.s_rdata;
            state      <= RD_J;
          end
        end
        RD_J: begin
          wcnt  <= WT_INIT;
          state <= WT_J;
        end
        WT_J: begin
          if (wcnt != 2'd0) begin
            wcnt <= wcnt - 2'd1;
          end else begin
            sj          <= bus.s_rdata;
            bus.s_addr  <= i;
            bus.s_wdata <= bus.s_rdata;
            bus.s_wren  <= 1'b1;
            state       <= WR_I;
          end
        end
        WR_I: begin
          bus.s_addr  <= j;
          bus.s_wdata <= si;
          bus.s_wren  <= 1'b1;
          state       <= WR_J;
        end
        WR_J: begin
          bus.s_addr  <= si + sj;
          bus.s_wdata <= '0;
          bus.e_addr  <= k;
          state       <= RD_F;
        end
        RD_F: begin
          wcnt  <= WT_INIT;
          state <= WT_F;
        end
        WT_F: begin
          if (wcnt != 2'd0) begin
            wcnt <= wcnt - 2'd1;
          end else begin
            bus.s_addr  <= '0;
            bus.e_addr  <= '0;
            bus.d_addr  <= k;
            bus.d_wdata <= bus.s_rdata ^ bus.e_rdata;
`ifdef RC4_PLAINTEXT_CHECK_EN
            bus.d_wren  <= is_text(bus.s_rdata ^ bus.e_rdata);
`else
            bus.d_wren  <= 1'b1;
`endif
            state       <= WR_D;
          end
        end
        WR_D: begin
          bus.d_addr  <= '0;
          bus.d_wdata <= '0;
          // A suppressed write marks a rejected byte and ends the run.
          if (!bus.d_wren || k == K_LAST) begin
            bus.done <= 1'b1;
            bus.ok   <= bus.d_wren;
            state    <= DONE;
          end else begin
            k          <= k + 1'b1;
            i          <= i + 8'd1;
            bus.s_addr <= i + 8'd1;
            state      <= RD_I;
          end
        end
        DONE: begin
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_prga_engine.sv
// Bench for rc4_prga_engine: directed scenarios plus randomized S/E images against a plain RC4 model.
module tb_rc4_prga_engine;
  localparam int L  = 4;
  localparam int AW = 3;
  localparam int R  = 2;
  localparam int CYC_PER_BYTE = 3 * R + 6;
`ifdef RC4_PLAINTEXT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  rc4_prga_engine_if #(.MSG_AW(AW)) bus();
  rc4_prga_engine #(.MSG_LEN(L), .MSG_AW(AW), .RD_LAT(R)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [7:0] s_mem [256];
  logic [7:0] perm  [256];
  logic [7:0] e_mem [2**AW];
  logic [7:0] d_mem [2**AW];
  logic [7:0] s_pipe [R];
  logic [7:0] e_pipe [R];
  logic load_req = 1'b0;
  logic clear_req = 1'b0;
  int   d_writes = 0;

  assign bus.s_rdata = s_pipe[R-1];
  assign bus.e_rdata = e_pipe[R-1];

  always @(posedge clk) begin
    s_pipe[0] <= s_mem[bus.s_addr];
    e_pipe[0] <= e_mem[bus.e_addr];
    for (int n = 1; n < R; n++) begin
      s_pipe[n] <= s_pipe[n-1];
      e_pipe[n] <= e_pipe[n-1];
    end
    if (load_req) begin
      for (int n = 0; n < 256; n++) s_mem[n] <= perm[n];
    end else if (bus.s_wren) begin
      s_mem[bus.s_addr] <= bus.s_wdata;
    end
    if (clear_req) begin
      for (int n = 0; n < 2**AW; n++) d_mem[n] <= 8'h00;
      d_writes <= 0;
    end else if (bus.d_wren) begin
      d_mem[bus.d_addr] <= bus.d_wdata;
      d_writes <= d_writes + 1;
    end
  end

  logic [34:0] all_outs;
  assign all_outs = {bus.busy, bus.done, bus.ok, bus.s_addr, bus.s_wdata, bus.s_wren,
                     bus.e_addr, bus.d_addr, bus.d_wdata, bus.d_wren};

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: textbook RC4 PRGA over a copy of the S image.
  logic [7:0] exp_s [256];
  logic [7:0] ks    [L];
  logic [7:0] exp_d [L];
  int exp_n;
  bit exp_ok;

  function automatic bit plain(input logic [7:0] v);
    return (v >= 8'h61 && v <= 8'h7a) || v == 8'h20;
  endfunction

  task automatic model();
    logic [7:0] sm [256];
    logic [7:0] a, b, t, v;
    bit stop;
    sm = perm;
    exp_s = perm;
    a = 8'd0;
    b = 8'd0;
    exp_n = 0;
    stop = 1'b0;
    for (int n = 0; n < L; n++) begin
      a = a + 8'd1;
      b = b + sm[a];
      t = sm[a]; sm[a] = sm[b]; sm[b] = t;
      t = sm[a] + sm[b];
      ks[n] = sm[t];
      v = ks[n] ^ e_mem[n];
      if (!stop) begin
        exp_s = sm;
        if (CHK && !plain(v)) stop = 1'b1;
        else begin
          exp_d[n] = v;
          exp_n++;
        end
      end
    end
    exp_ok = (exp_n == L);
  endtask

  task automatic set_ident();
    for (int n = 0; n < 256; n++) perm[n] = 8'(n);
  endtask

  task automatic set_e(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
    for (int n = 0; n < 2**AW; n++) e_mem[n] = 8'h00;
    e_mem[0] = b0; e_mem[1] = b1; e_mem[2] = b2; e_mem[3] = b3;
  endtask

  task automatic load();
    @(negedge clk);
    load_req = 1'b1;
    clear_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    clear_req = 1'b0;
  endtask

  task automatic do_run(input int pulse_at, input bit hold, output int cycles);
    int bytes;
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
    cycles = 1;
    chk("busy_rise", 64'(bus.busy), 64'd1);
    while (!bus.done && cycles < 1000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (cycles == pulse_at) bus.start = 1'b1;
      else if (!hold) bus.start = 1'b0;
    end
    bytes = exp_ok ? L : exp_n + 1;
    chk("done_seen", 64'(bus.done), 64'd1);
    chk("ok_at_done", 64'(bus.ok), 64'(exp_ok));
    chk("run_cycles", 64'(cycles), 64'(CYC_PER_BYTE * bytes + 1));
  endtask

  task automatic after_done();
    @(posedge clk);
    #1;
    chk("done_pulse_end", 64'(bus.done), 64'd0);
    chk("busy_fall", 64'(bus.busy), 64'd0);
    chk("ok_hold", 64'(bus.ok), 64'(exp_ok));
  endtask

  task automatic check_run();
    int diffs;
    for (int n = 0; n < exp_n; n++) chk("d_byte", 64'(d_mem[n]), 64'(exp_d[n]));
    chk("d_writes", 64'(d_writes), 64'(exp_n));
    diffs = 0;
    for (int n = 0; n < 256; n++) if (s_mem[n] !== exp_s[n]) diffs++;
    chk("s_final", 64'(diffs), 64'd0);
  endtask

  task automatic scen1_consts();
    chk("s1_d0", 64'(d_mem[0]), 64'h02);
    chk("s1_d1", 64'(d_mem[1]), 64'h05);
    chk("s1_d2", 64'(d_mem[2]), 64'h07);
    chk("s1_d3", 64'(d_mem[3]), 64'h0D);
    chk("s1_ok", 64'(bus.ok), 64'd1);
    chk("s1_S2", 64'(s_mem[2]), 64'h03);
    chk("s1_S3", 64'(s_mem[3]), 64'h05);
    chk("s1_S4", 64'(s_mem[4]), 64'h09);
    chk("s1_S5", 64'(s_mem[5]), 64'h02);
    chk("s1_S9", 64'(s_mem[9]), 64'h04);
  endtask

  task automatic set_e_scen1();
`ifdef RC4_PLAINTEXT_CHECK_EN
    set_e(8'h63, 8'h64, 8'h66, 8'h6C);
`else
    set_e(8'h00, 8'h00, 8'h00, 8'h00);
`endif
  endtask

  initial begin
    int cyc, g, r;
    logic [7:0] t, pt;
    bus.start = 1'b0;
    #2 reset = 1'b1;
    #10;
    chk("reset_outputs", 64'(all_outs), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Identity S; expected bytes and timing worked out by hand
    set_ident();
`ifdef RC4_PLAINTEXT_CHECK_EN
    set_e(8'h63, 8'h64, 8'h66, 8'h6C);
    load(); model();
    do_run(0, 1'b0, cyc); after_done(); check_run();
    for (int n = 0; n < L; n++) chk("s2_d", 64'(d_mem[n]), 64'h61);
    chk("s2_ok", 64'(bus.ok), 64'd1);
    set_ident();
    set_e(8'h63, 8'h64, 8'h46, 8'h6C);
    load(); model();
    do_run(0, 1'b0, cyc); after_done(); check_run();
    chk("s3_d0", 64'(d_mem[0]), 64'h61);
    chk("s3_d1", 64'(d_mem[1]), 64'h61);
    chk("s3_writes", 64'(d_writes), 64'd2);
    chk("s3_ok", 64'(bus.ok), 64'd0);
`else
    set_e(8'h00, 8'h00, 8'h00, 8'h00);
    load(); model();
    do_run(0, 1'b0, cyc); after_done(); check_run();
    chk("s4_cycles", 64'(cyc), 64'd49);
    scen1_consts();
`endif

    // Reset mid-run after the first decrypted write, then rerun from a fresh S
    set_ident(); set_e_scen1(); load(); model();
    @(negedge clk);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    g = 0;
    while (!bus.d_wren && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("s5_first_dwren", 64'(bus.d_wren), 64'd1);
    reset = 1'b1;
    #1;
    chk("s5_reset_outputs", 64'(all_outs), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    set_ident(); set_e_scen1(); load(); model();
    do_run(0, 1'b0, cyc); after_done(); check_run();
`ifndef RC4_PLAINTEXT_CHECK_EN
    scen1_consts();
`endif

    // start pulsed while busy must not change the run length
    set_ident(); set_e_scen1(); load(); model();
    do_run(5, 1'b0, cyc); after_done(); check_run();

    // start held through DONE: next run begins in the following IDLE cycle
    set_ident(); set_e_scen1(); load(); model();
    do_run(0, 1'b1, cyc); after_done();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("s6_restart_busy", 64'(bus.busy), 64'd1);
    chk("s6_restart_ok", 64'(bus.ok), 64'd0);
    g = 0;
    while (!bus.done && g < 1000) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("s6_second_done", 64'(bus.done), 64'd1);
    @(posedge clk);
    #1;

    // Random permutations; ciphertext built from mostly-valid plaintext
    repeat (6) begin
      set_ident();
      for (int n = 255; n > 0; n--) begin
        r = int'($urandom_range(0, n));
        t = perm[n]; perm[n] = perm[r]; perm[r] = t;
      end
      for (int n = 0; n < 2**AW; n++) e_mem[n] = 8'h00;
      model();
      for (int n = 0; n < L; n++) begin
        r = int'($urandom_range(0, 26));
        pt = (r == 26) ? 8'h20 : 8'(8'h61 + r);
        if ($urandom_range(0, 9) == 0) pt = 8'($urandom_range(0, 255));
        e_mem[n] = pt ^ ks[n];
      end
      model();
      load();
      do_run(0, 1'b0, cyc); after_done(); check_run();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rc4_prga_engine.md
# rc4_prga_engine

Parametrised RC4 keystream-generation and decryption engine (PRGA phase). It runs after the key-schedule block has left a permuted S array in the shared 256×8 S RAM. It produces MSG_LEN keystream bytes, XORs each with the encrypted ROM byte and writes the result to the decrypted RAM. Compared with the single-shot decrypt FSM, it adds configurable message length and memory read latency, separate address buses per memory, a restartable start/busy/done handshake, and optional plaintext validation with early abort for key-search use.

## Interface

Parameters:
- MSG_LEN, 32: message bytes per run, 1..256.
- MSG_AW, 5: message address width; 2^MSG_AW ≥ MSG_LEN.
- RD_LAT, 2: synchronous read latency of all memories in cycles, 1..3.

Ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high; one clock, async active-high reset.
- start  in  1  run request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse in DONE.
- ok  out  1  result of the last run; stable from DONE until the next accepted start.
- s_addr  out  8  S RAM address.
- s_wdata  out  8  S RAM write data.
- s_wren  out  1  S RAM write enable.
- s_rdata  in  8  S RAM read data.
- e_addr  out  MSG_AW  encrypted ROM address.
- e_rdata  in  8  encrypted ROM data.
- d_addr  out  MSG_AW  decrypted RAM address.
- d_wdata  out  8  decrypted RAM write data.
- d_wren  out  1  decrypted RAM write enable.

## Operation

- Internal registers: i, j, si, sj (8-bit); k (MSG_AW bits); f (8-bit).
- All arithmetic is 8-bit modulo 256, with carries discarded.
- On an accepted start: i = j = k = 0, ok = 0, then enter RD_I.
- Per byte:
  - RD_I: i ← i+1; drive s_addr = i+1.
  - WT_I ×RD_LAT: hold s_addr. On the last cycle, capture si = s_rdata and set j ← j+si.
  - RD_J: drive s_addr = j.
  - WT_J ×RD_LAT: hold s_addr. On the last cycle, capture sj.
  - WR_I: s_addr = i, s_wdata = sj, s_wren = 1.
  - WR_J: s_addr = j, s_wdata = si, s_wren = 1.
  - RD_F: s_addr = si+sj; e_addr = k.
  - WT_F ×RD_LAT: hold both addresses. On the last cycle, capture f = s_rdata.
  - WR_D: d_addr = k, d_wdata = f ^ e_rdata, d_wren = 1 (subject to the check under Configuration).
    - If k == MSG_LEN-1, go to DONE.
    - Otherwise k ← k+1 and go to RD_I.
- DONE: done = 1 for one cycle, then IDLE.
  - ok = 1 if all MSG_LEN bytes were written.
  - ok = 0 on abort.
- Writes are single-cycle with no readback polling.
- When i == j, both swap writes target the same address. The value is unchanged, which is legal.
- Address and data outputs are valid only while the matching wren is high or during read states. In IDLE they hold 0.
- start while busy is ignored. start held high through DONE is accepted in the following IDLE cycle (back-to-back runs).
- reset mid-run:
  - All outputs go to 0 immediately; no further writes occur.
  - The S RAM is left partially permuted. The caller must re-run the key schedule before the next start.

## Timing

- Reset values: busy = done = ok = 0; all wren = 0; all address and data outputs = 0; state = IDLE.
- All outputs are registered.
- Cycles per byte = 3·RD_LAT + 6 (12 at RD_LAT = 2).
- done is asserted (3·RD_LAT+6)·MSG_LEN + 1 cycles after the edge that samples start.
- busy rises on the edge after start is sampled and falls on the edge after done.

## Configuration

- RC4_PLAINTEXT_CHECK_EN defined:
  - In WR_D, the value f ^ e_rdata must be 0x61..0x7A or 0x20.
  - If it is not, d_wren stays 0, the byte is not written, and the FSM goes straight to DONE with ok = 0.
- RC4_PLAINTEXT_CHECK_EN undefined: every byte is written, and ok = 1 on every completed run.

## Test plan

- Setup for scenarios 1–3: S identity (s[n] = n), MSG_LEN = 4, RD_LAT = 2.
- Scenario 1: check undefined, e = 00 00 00 00 → d = 02 05 07 0D; ok = 1; S[2]=03, S[3]=05, S[4]=09, S[5]=02, S[9]=04.
- Scenario 2: check defined, e = 63 64 66 6C → d = 61 61 61 61; ok = 1.
- Scenario 3: check defined, e = 63 64 46 6C → d[0..1] = 61 61; no write at d[2] or d[3]; done with ok = 0.
- Scenario 4: cycle count for scenario 1 → done exactly 49 cycles after start is sampled; busy high for 49 cycles; done high for 1 cycle.
- Scenario 5: assert reset after the first d_wren → all outputs are 0 in the same cycle. Reload identity S and start → output matches scenario 1 (i and j restart at 0).
- Scenario 6: pulse start during busy → ignored, with no extra cycles. Hold start through done → a second run begins one cycle after done with ok cleared to 0.
